// File: rtl/dmem_port_pkg.sv
// Shared definitions for the data-memory port: store size encodings,
// controller states and small decode helpers.
package dmem_port_pkg;

   localparam int MEM_AW_DEFAULT = 30;

   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      RMW_RD = 3'd2,
      RMW_WR = 3'd3,
      WR     = 3'd4,
      DONE   = 3'd5
   } state_e;

   // States in which a request is outstanding on the SRAM interface.
   function automatic logic is_busy(input state_e s);
      return (s == RD) || (s == RMW_RD) || (s == RMW_WR) || (s == WR);
   endfunction

   function automatic logic is_sub_word(input logic [1:0] size);
      return (size == SZ_BYTE) || (size == SZ_HALF);
   endfunction

   function automatic logic is_misaligned_half(input logic [1:0] size, input logic addr0);
      return (size == SZ_HALF) && addr0;
   endfunction

endpackage

// File: rtl/dmem_merge.sv
// Combinational sub-word merge for read-modify-write stores.
// Big-endian lanes: byte offset 0 occupies bits [31:24].
module dmem_merge
   import dmem_port_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_data,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   output logic [31:0] merged
);

   // NOTE: merged gets a default first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      merged = old_word;
      case (size)
         SZ_BYTE: begin
            case (offset)
               2'd0: merged[31:24] = new_data[7:0];
               2'd1: merged[23:16] = new_data[7:0];
               2'd2: merged[15:8]  = new_data[7:0];
               2'd3: merged[7:0]   = new_data[7:0];
               default: merged = old_word;
            endcase
         end
         SZ_HALF: begin
            if (offset[1]) merged[15:0]  = new_data[15:0];
            else           merged[31:16] = new_data[15:0];
         end
         default: merged = new_data;
      endcase
   end

endmodule

// File: rtl/dmem_port.sv
// Data-memory port between the MEM stage and a word-only, variable-latency
// SRAM: loads, word stores and read-modify-write for byte/half stores.
module dmem_port
   import dmem_port_pkg::*;
#(
   parameter int          MEM_AW      = MEM_AW_DEFAULT,
   parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              MemRead_IN,
   input  logic              MemWrite_IN,
   input  logic [31:0]       data_address_IN,
   input  logic [31:0]       data_write_IN,
   input  logic [1:0]        data_write_size_IN,
   output logic [31:0]       data_read_OUT,
   output logic              STALL_OUT,
   output logic              align_err_OUT,
   output logic [MEM_AW-1:0] mem_addr_OUT,
   output logic              mem_req_OUT,
   output logic              mem_we_OUT,
   output logic [31:0]       mem_wdata_OUT,
   input  logic [31:0]       mem_rdata_IN,
   input  logic              mem_ack_IN
);

   state_e            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       data_read_q, data_read_d;
   logic              align_err_q, align_err_d;
   logic [31:0]       sub_q, sub_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       merged;
   logic              misaligned;

   assign misaligned = is_misaligned_half(data_write_size_IN, data_address_IN[0]);

   dmem_merge u_merge (
      .old_word (mem_rdata_IN),
      .new_data (sub_q),
      .size     (size_q),
      .offset   (off_q),
      .merged   (merged)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (MemWrite_IN) begin
               if (misaligned)                           state_d = DONE;
               else if (is_sub_word(data_write_size_IN)) state_d = RMW_RD;
               else                                      state_d = WR;
            end else if (MemRead_IN) begin
               state_d = RD;
            end
         end
         RD:      if (mem_ack_IN) state_d = DONE;
         RMW_RD:  if (mem_ack_IN) state_d = RMW_WR;
         RMW_WR:  if (mem_ack_IN) state_d = DONE;
         WR:      if (mem_ack_IN) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // DONE deliberately drops the stall so the pipeline advances exactly one edge.
   always_comb begin
      STALL_OUT = 1'b0;
      case (state_q)
         IDLE:                  STALL_OUT = MemRead_IN | MemWrite_IN;
         RD, RMW_RD, RMW_WR, WR: STALL_OUT = 1'b1;
         default:               STALL_OUT = 1'b0;
      endcase
   end

   // SRAM request and write-enable follow the next state, so they rise and fall registered.
   always_comb begin
      mem_req_d   = is_busy(state_d);
      mem_we_d    = (state_d == RMW_WR) || (state_d == WR);
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      data_read_d = data_read_q;
      align_err_d = 1'b0;
      sub_d       = sub_q;
      size_d      = size_q;
      off_d       = off_q;
      case (state_q)
         IDLE: begin
            if (MemWrite_IN) begin
               if (misaligned) begin
                  align_err_d = 1'b1;
               end else begin
                  mem_addr_d  = data_address_IN[MEM_AW+1:2];
                  mem_wdata_d = data_write_IN;
                  sub_d       = data_write_IN;
                  size_d      = data_write_size_IN;
                  off_d       = data_address_IN[1:0];
               end
            end else if (MemRead_IN) begin
               mem_addr_d = data_address_IN[MEM_AW+1:2];
            end
         end
         RD:      if (mem_ack_IN) data_read_d = mem_rdata_IN;
         RMW_RD:  if (mem_ack_IN) mem_wdata_d = merged;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         data_read_q <= RESET_RDATA;
         align_err_q <= 1'b0;
         sub_q       <= '0;
         size_q      <= SZ_WORD;
         off_q       <= '0;
      end else begin
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         data_read_q <= data_read_d;
         align_err_q <= align_err_d;
         sub_q       <= sub_d;
         size_q      <= size_d;
         off_q       <= off_d;
      end
   end

   assign mem_req_OUT   = mem_req_q;
   assign mem_we_OUT    = mem_we_q;
   assign mem_addr_OUT  = mem_addr_q;
   assign mem_wdata_OUT = mem_wdata_q;
   assign data_read_OUT = data_read_q;
   assign align_err_OUT = align_err_q;

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboard bench for dmem_port: an SRAM model with programmable ack latency
// and a monitor that checks every SRAM transaction, load result and align pulse.
module tb_dmem_port;

   localparam logic [31:0] RST_RD = 32'hA5A5_0F0F;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        MemRead_IN, MemWrite_IN;
   logic [31:0] data_address_IN, data_write_IN;
   logic [1:0]  data_write_size_IN;
   logic [31:0] data_read_OUT;
   logic        STALL_OUT, align_err_OUT;
   logic [29:0] mem_addr_OUT;
   logic        mem_req_OUT, mem_we_OUT;
   logic [31:0] mem_wdata_OUT, mem_rdata_IN;
   logic        mem_ack_IN;

   dmem_port #(.MEM_AW(30), .RESET_RDATA(RST_RD)) dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .MemRead_IN         (MemRead_IN),
      .MemWrite_IN        (MemWrite_IN),
      .data_address_IN    (data_address_IN),
      .data_write_IN      (data_write_IN),
      .data_write_size_IN (data_write_size_IN),
      .data_read_OUT      (data_read_OUT),
      .STALL_OUT          (STALL_OUT),
      .align_err_OUT      (align_err_OUT),
      .mem_addr_OUT       (mem_addr_OUT),
      .mem_req_OUT        (mem_req_OUT),
      .mem_we_OUT         (mem_we_OUT),
      .mem_wdata_OUT      (mem_wdata_OUT),
      .mem_rdata_IN       (mem_rdata_IN),
      .mem_ack_IN         (mem_ack_IN)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic        is_load;
   } tx_t;

   tx_t         exp_tx[$];
   logic [31:0] exp_rd[$];
   bit          exp_align[$];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] sram [logic [29:0]];
   int          wait_cycles = 0;
   int          req_cnt     = 0;
   bit          const_ack   = 1'b0;
   bit          wr_hold     = 1'b0;
   bit          stray_ack   = 1'b0;
   bit          rd_pending  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // SRAM model: acks after wait_cycles request cycles, or every cycle in const_ack mode.
   always @(negedge CLK) begin
      mem_ack_IN = 1'b0;
      if (stray_ack) begin
         mem_ack_IN = 1'b1;
         stray_ack  = 1'b0;
      end else if (mem_req_OUT && !(wr_hold && mem_we_OUT) &&
                   (const_ack || req_cnt == wait_cycles)) begin
         mem_ack_IN   = 1'b1;
         mem_rdata_IN = sram.exists(mem_addr_OUT) ? sram[mem_addr_OUT] : 32'h0;
         if (mem_we_OUT) sram[mem_addr_OUT] = mem_wdata_OUT;
         req_cnt = 0;
      end else if (mem_req_OUT) begin
         req_cnt++;
      end else begin
         req_cnt = 0;
      end
      if (const_ack) mem_ack_IN = 1'b1;
   end

   // Monitor: compares whatever the DUT presents against the expectation queues.
   always @(negedge CLK) begin
      tx_t e;
      #1;
      if (rd_pending) begin
         rd_pending = 1'b0;
         if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL load_unexpected: data_read_OUT %h with no load pending", data_read_OUT);
         end else begin
            check("load_data", data_read_OUT, exp_rd.pop_front());
         end
      end
      if (mem_req_OUT && mem_ack_IN) begin
         if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: we %b addr %h wdata %h", mem_we_OUT, mem_addr_OUT, mem_wdata_OUT);
         end else begin
            e = exp_tx.pop_front();
            check("tx_we", mem_we_OUT, e.we);
            check("tx_addr", mem_addr_OUT, e.addr);
            if (e.we) check("tx_wdata", mem_wdata_OUT, e.wdata);
            if (e.is_load) rd_pending = 1'b1;
         end
      end
      if (align_err_OUT) begin
         if (exp_align.size() == 0) begin
            checks++; errors++;
            $display("FAIL align_unexpected: align_err_OUT high with no misaligned store pending");
         end else begin
            void'(exp_align.pop_front());
            check("align_no_req", mem_req_OUT, 1'b0);
         end
      end
   end

   task automatic exp_load(input logic [29:0] a, input logic [31:0] d);
      exp_tx.push_back('{we: 1'b0, addr: a, wdata: 32'h0, is_load: 1'b1});
      exp_rd.push_back(d);
   endtask

   task automatic exp_write(input logic [29:0] a, input logic [31:0] d);
      exp_tx.push_back('{we: 1'b1, addr: a, wdata: d, is_load: 1'b0});
   endtask

   task automatic exp_rmw(input logic [29:0] a, input logic [31:0] d);
      exp_tx.push_back('{we: 1'b0, addr: a, wdata: 32'h0, is_load: 1'b0});
      exp_write(a, d);
   endtask

   // Presents a request and holds it while STALL_OUT is high; returns in the release cycle.
   task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] sz, output int stalls);
      @(negedge CLK);
      MemRead_IN = rd; MemWrite_IN = wr;
      data_address_IN = a; data_write_IN = d; data_write_size_IN = sz;
      #1;
      stalls = 0;
      while (STALL_OUT === 1'b1 && stalls < 200) begin
         stalls++;
         @(negedge CLK); #1;
      end
      if (stalls >= 200) begin
         checks++; errors++;
         $display("FAIL op_timeout: STALL_OUT still high after %0d cycles", stalls);
      end
   endtask

   task automatic idle();
      @(negedge CLK);
      MemRead_IN = 1'b0; MemWrite_IN = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st;
      int n;
      RESET = 1'b1; MemRead_IN = 1'b0; MemWrite_IN = 1'b0;
      data_address_IN = '0; data_write_IN = '0; data_write_size_IN = '0;
      mem_ack_IN = 1'b0; mem_rdata_IN = '0;
      sram[30'h40] = 32'hDEAD_BEEF;
      sram[30'h80] = 32'h1122_3344;
      sram[30'h02] = 32'h0102_0304;
      sram[30'h00] = 32'h0102_0304;
      sram[30'h01] = 32'hA0B0_C0D0;

      repeat (3) @(negedge CLK);
      #1;
      check("rst_req", mem_req_OUT, 1'b0);
      check("rst_we", mem_we_OUT, 1'b0);
      check("rst_addr", mem_addr_OUT, 30'h0);
      check("rst_wdata", mem_wdata_OUT, 32'h0);
      check("rst_rdata", data_read_OUT, RST_RD);
      check("rst_align", align_err_OUT, 1'b0);
      check("rst_stall", STALL_OUT, 1'b0);
      @(negedge CLK); RESET = 1'b0;

      // Word load, ack after one wait cycle.
      wait_cycles = 1;
      exp_load(30'h40, 32'hDEAD_BEEF);
      run_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'd0, st);
      check("load_stall_cycles", st, 3);
      check("load_mem_addr", mem_addr_OUT, 30'h40);
      check("load_req_low_done", mem_req_OUT, 1'b0);
      idle();

      // Byte stores, zero-wait ack; upper store-data bits must be ignored.
      wait_cycles = 0;
      exp_rmw(30'h80, 32'h1122_33A5);
      run_op(1'b0, 1'b1, 32'h0000_0203, 32'hFFFF_FFA5, 2'd1, st);
      check("byte3_stall_cycles", st, 3);
      check("byte3_rdata_hold", data_read_OUT, 32'hDEAD_BEEF);
      idle();
      exp_rmw(30'h80, 32'h5A22_33A5);
      run_op(1'b0, 1'b1, 32'h0000_0200, 32'h1234_565A, 2'd1, st);
      idle();

      // Half stores at both aligned offsets.
      sram[30'h80] = 32'hCAFE_0000;
      exp_rmw(30'h80, 32'hCAFE_BEEF);
      run_op(1'b0, 1'b1, 32'h0000_0202, 32'h7777_BEEF, 2'd2, st);
      idle();
      exp_rmw(30'h80, 32'h1234_BEEF);
      run_op(1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 2'd2, st);
      idle();

      // Misaligned half store: no SRAM access, one-cycle align pulse.
      exp_align.push_back(1'b1);
      run_op(1'b0, 1'b1, 32'h0000_0201, 32'h0000_FFFF, 2'd2, st);
      check("misalign_stall_cycles", st, 1);
      check("misalign_req", mem_req_OUT, 1'b0);
      idle();
      #1;
      check("misalign_pulse_end", align_err_OUT, 1'b0);

      // Read and write together: only the word store is performed.
      exp_write(30'h04, 32'h1234_5678);
      run_op(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 2'd0, st);
      check("both_stall_cycles", st, 2);
      check("both_rdata_hold", data_read_OUT, 32'hDEAD_BEEF);
      idle();

      // Reserved size behaves as a word store.
      exp_write(30'h05, 32'h0BAD_F00D);
      run_op(1'b0, 1'b1, 32'h0000_0014, 32'h0BAD_F00D, 2'd3, st);
      idle();

      // Reset while the RMW write is waiting for an ack that never comes.
      wr_hold = 1'b1;
      exp_tx.push_back('{we: 1'b0, addr: 30'h02, wdata: 32'h0, is_load: 1'b0});
      @(negedge CLK);
      MemWrite_IN = 1'b1; data_address_IN = 32'h0000_0008;
      data_write_IN = 32'h0000_00EE; data_write_size_IN = 2'd1;
      #1;
      n = 0;
      while (!(mem_req_OUT && mem_we_OUT) && n < 50) begin
         @(negedge CLK); #1;
         n++;
      end
      check("rmw_wr_reached", {mem_req_OUT, mem_we_OUT}, 2'b11);
      check("rmw_wr_wdata", mem_wdata_OUT, 32'hEE02_0304);
      RESET = 1'b1; MemWrite_IN = 1'b0;
      @(negedge CLK); #1;
      check("abort_req", mem_req_OUT, 1'b0);
      check("abort_we", mem_we_OUT, 1'b0);
      check("abort_rdata", data_read_OUT, RST_RD);
      check("abort_stall", STALL_OUT, 1'b0);
      RESET = 1'b0; wr_hold = 1'b0;
      stray_ack = 1'b1;
      @(negedge CLK); #1;
      @(negedge CLK); #1;
      check("stray_req", mem_req_OUT, 1'b0);
      check("stray_stall", STALL_OUT, 1'b0);
      check("stray_rdata", data_read_OUT, RST_RD);
      wait_cycles = 1;
      exp_load(30'h40, 32'hDEAD_BEEF);
      run_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'd0, st);
      check("post_reset_stall_cycles", st, 3);
      idle();

      // Back-to-back loads with ack held high; low address bits are ignored.
      const_ack = 1'b1;
      exp_load(30'h00, 32'h0102_0304);
      exp_load(30'h01, 32'hA0B0_C0D0);
      exp_load(30'h01, 32'hA0B0_C0D0);
      run_op(1'b1, 1'b0, 32'h0000_0000, 32'h0, 2'd0, st);
      check("b2b_first_stall", st, 2);
      run_op(1'b1, 1'b0, 32'h0000_0004, 32'h0, 2'd0, st);
      check("b2b_second_stall", st, 2);
      run_op(1'b1, 1'b0, 32'h0000_0007, 32'h0, 2'd0, st);
      check("b2b_third_stall", st, 2);
      idle();
      const_ack = 1'b0;

      repeat (4) idle();
      check("tx_queue_drained", exp_tx.size(), 0);
      check("rd_queue_drained", exp_rd.size(), 0);
      check("align_queue_drained", exp_align.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
